// File: rtl/timer_array_pkg.sv
// Shared state encodings and default widths for the timer array.
package timer_array_pkg;

    localparam int unsigned DEF_NUM_CH  = 4;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_PRESC_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_array_channel.sv
// One timer channel: prescaler, tick counter, expiry FSM, sticky status/overrun.
module timer_channel
    import timer_array_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned PRESC_W = DEF_PRESC_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_cont,
    input  logic [CNT_W-1:0]   i_period,
    input  logic [PRESC_W-1:0] i_prescale,
    input  logic               i_irq_clear,
    output logic               o_status,
    output logic               o_overrun,
    output logic               o_active,
    output logic [CNT_W-1:0]   o_count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               status_q, status_d;
    logic               overrun_q, overrun_d;

    logic [CNT_W-1:0]   term_c;
    logic               tick_c;
    logic               expire_c;

    // Period 0 behaves as period 1; >= on the prescaler keeps a live lowering of
    // i_prescale from wrapping the prescaler all the way round.
    assign term_c   = (i_period == '0) ? '0 : i_period - CNT_W'(1);
    assign tick_c   = (state_q == ST_RUN) && (presc_q >= i_prescale);
    assign expire_c = i_en && tick_c && (cnt_q >= term_c);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        presc_d   = presc_q;
        status_d  = status_q;
        overrun_d = overrun_q;

        if (i_irq_clear) begin
            status_d  = 1'b0;
            overrun_d = 1'b0;
        end

        if (!i_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    presc_d = '0;
                end
                ST_RUN: begin
                    if (tick_c) begin
                        presc_d = '0;
                        if (!expire_c) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        // Expiry sets status even against a same-cycle clear.
        if (expire_c) begin
            status_d = 1'b1;
            if (status_q && !i_irq_clear) begin
                overrun_d = 1'b1;
            end
            if (i_cont) begin
                cnt_d = '0;
            end else begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            presc_q   <= '0;
            status_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            status_q  <= status_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_status  = status_q;
    assign o_overrun = overrun_q;
    assign o_active  = (state_q == ST_RUN);
    assign o_count   = cnt_q;

endmodule

// File: rtl/timer_array.sv
// Multi-channel timer array: per-channel timers plus masked interrupt reduction.
module timer_array
    import timer_array_pkg::*;
#(
    parameter int unsigned NUM_CH  = DEF_NUM_CH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned PRESC_W = DEF_PRESC_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_en,
    input  logic [NUM_CH-1:0]         i_cont,
    input  logic [NUM_CH*CNT_W-1:0]   i_period,
    input  logic [PRESC_W-1:0]        i_prescale,
    input  logic [NUM_CH-1:0]         i_irq_clear,
    input  logic [NUM_CH-1:0]         i_irq_mask,
    output logic [NUM_CH-1:0]         o_irq_status,
    output logic [NUM_CH-1:0]         o_overrun,
    output logic                      o_irq,
    output logic [NUM_CH-1:0]         o_active,
    output logic [NUM_CH*CNT_W-1:0]   o_count
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_en        (i_en[n]),
            .i_cont      (i_cont[n]),
            .i_period    (i_period[n*CNT_W +: CNT_W]),
            .i_prescale  (i_prescale),
            .i_irq_clear (i_irq_clear[n]),
            .o_status    (o_irq_status[n]),
            .o_overrun   (o_overrun[n]),
            .o_active    (o_active[n]),
            .o_count     (o_count[n*CNT_W +: CNT_W])
        );
    end

    // Mask is applied after the status flops so it acts within the same cycle.
    assign o_irq = |(o_irq_status & i_irq_mask);

endmodule

// File: tb/tb_timer_array.sv
// Scoreboard bench for timer_array: directed scenarios plus random stimulus vs a reference model.
module tb_timer_array;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PW  = 8;

    typedef struct packed {
        logic [NCH-1:0]    st;
        logic [NCH-1:0]    ov;
        logic [NCH-1:0]    act;
        logic              irq;
        logic [NCH*CW-1:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    en, cont, clr, mask;
    logic [NCH*CW-1:0] period;
    logic [PW-1:0]     presc;
    logic [NCH-1:0]    o_irq_status, o_overrun, o_active;
    logic              o_irq;
    logic [NCH*CW-1:0] o_count;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    exp_t sb_q[$];

    // Reference model state: armed/finished flags and plain integer counters.
    bit m_run[NCH], m_done[NCH], m_st[NCH], m_ov[NCH];
    int m_cnt[NCH], m_pre[NCH];

    timer_array #(.NUM_CH(NCH), .CNT_W(CW), .PRESC_W(PW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_cont       (cont),
        .i_period     (period),
        .i_prescale   (presc),
        .i_irq_clear  (clr),
        .i_irq_mask   (mask),
        .o_irq_status (o_irq_status),
        .o_overrun    (o_overrun),
        .o_irq        (o_irq),
        .o_active     (o_active),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, expv);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_run[n] = 0; m_done[n] = 0; m_st[n] = 0; m_ov[n] = 0;
            m_cnt[n] = 0; m_pre[n] = 0;
        end
    endtask

    // Advance the model by one rising edge with the current inputs and queue the result.
    task automatic model_step();
        exp_t e;
        bit   xp;
        int   per, term;
        e = '0;
        for (int n = 0; n < NCH; n++) begin
            xp   = 0;
            per  = int'(period[n*CW +: CW]);
            term = (per == 0) ? 0 : per - 1;
            if (!en[n]) begin
                m_run[n] = 0; m_done[n] = 0; m_cnt[n] = 0; m_pre[n] = 0;
            end else if (!m_run[n] && !m_done[n]) begin
                m_run[n] = 1; m_cnt[n] = 0; m_pre[n] = 0;
            end else if (m_run[n]) begin
                if (m_pre[n] >= int'(presc)) begin
                    m_pre[n] = 0;
                    if (m_cnt[n] >= term) xp = 1;
                    else m_cnt[n] = m_cnt[n] + 1;
                end else begin
                    m_pre[n] = m_pre[n] + 1;
                end
            end
            if (xp) begin
                m_ov[n] = clr[n] ? 1'b0 : (m_ov[n] | m_st[n]);
                m_st[n] = 1;
                if (cont[n]) m_cnt[n] = 0;
                else begin m_run[n] = 0; m_done[n] = 1; end
            end else if (clr[n]) begin
                m_st[n] = 0; m_ov[n] = 0;
            end
            e.st[n]  = m_st[n];
            e.ov[n]  = m_ov[n];
            e.act[n] = m_run[n];
            e.cnt[n*CW +: CW] = CW'(m_cnt[n]);
        end
        e.irq = |(e.st & mask);
        sb_q.push_back(e);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_per(input int ch, input int p);
        period[ch*CW +: CW] = CW'(p);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_status"},  64'(o_irq_status), 64'd0);
        chk({tag, "_overrun"}, 64'(o_overrun),    64'd0);
        chk({tag, "_active"},  64'(o_active),     64'd0);
        chk({tag, "_count"},   64'(o_count),      64'd0);
        chk({tag, "_irq"},     64'(o_irq),        64'd0);
    endtask

    // Monitor: every cycle the DUT presents registered outputs; compare with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_status",  64'(o_irq_status), 64'(e.st));
                    chk("sb_overrun", 64'(o_overrun),    64'(e.ov));
                    chk("sb_active",  64'(o_active),     64'(e.act));
                    chk("sb_irq",     64'(o_irq),        64'(e.irq));
                    chk("sb_count",   64'(o_count),      64'(e.cnt));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = '0; cont = '0; clr = '0; mask = '0; period = '0; presc = '0;
        model_reset();
        #1;
        chk_all_zero("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // One-shot ch0, P=5, S=0.
        set_per(0, 5); en[0] = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 5) chk("os_status_early", 64'(o_irq_status[0]), 64'd0);
            if (k == 6) begin
                chk("os_status_rise", 64'(o_irq_status[0]), 64'd1);
                chk("os_active_fall", 64'(o_active[0]), 64'd0);
                chk("os_count_hold", 64'(o_count[0 +: CW]), 64'd4);
            end
        end
        chk("os_no_reexpire", 64'(o_overrun[0]), 64'd0);
        chk("os_count_final", 64'(o_count[0 +: CW]), 64'd4);

        // Re-arm ch0 and reset asynchronously with count=3.
        en[0] = 1'b0; step();
        en[0] = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("rst_pre_count", 64'(o_count[0 +: CW]), 64'd3);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_async");
        sb_q.delete();
        model_reset();
        @(negedge clk);
        en = '0;
        rst = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("rst_stay_idle", 64'(o_active), 64'd0);

        // Continuous ch1, P=7, S=1: expiries every 14 clocks, clear, then overrun.
        set_per(1, 7); presc = 8'd1; cont[1] = 1'b1; en[1] = 1'b1;
        for (int k = 1; k <= 43; k++) begin
            clr = (k == 16) ? 4'b0010 : 4'b0000;
            step();
            if (k == 14) chk("ct_status_early", 64'(o_irq_status[1]), 64'd0);
            if (k == 15) chk("ct_status_14",    64'(o_irq_status[1]), 64'd1);
            if (k == 16) chk("ct_cleared",      64'(o_irq_status[1]), 64'd0);
            if (k == 28) chk("ct_status_pre28", 64'(o_irq_status[1]), 64'd0);
            if (k == 29) chk("ct_status_28",    64'(o_irq_status[1]), 64'd1);
            if (k == 42) chk("ct_ovr_pre42",    64'(o_overrun[1]),    64'd0);
            if (k == 43) chk("ct_ovr_42",       64'(o_overrun[1]),    64'd1);
        end
        clr = '0; en[1] = 1'b0; presc = '0; step();

        // Mask: ch2 expires masked, then unmasking raises o_irq combinationally.
        set_per(2, 3); en[2] = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("mask_status", 64'(o_irq_status[2]), 64'd1);
        chk("mask_irq_off", 64'(o_irq), 64'd0);
        mask = 4'b0100;
        #1 chk("mask_irq_on", 64'(o_irq), 64'd1);
        step();

        // Coincident clear and expiry on ch3 with status already set.
        set_per(3, 2); cont[3] = 1'b1; en[3] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            clr = (k == 5) ? 4'b1000 : 4'b0000;
            step();
            if (k == 3) chk("co_status_set", 64'(o_irq_status[3]), 64'd1);
        end
        chk("co_status_wins", 64'(o_irq_status[3]), 64'd1);
        chk("co_no_overrun",  64'(o_overrun[3]),    64'd0);
        clr = '0; en = '0; step();

        // Period 0 on ch0: expires every clock.
        clr = 4'b1111; step(); clr = '0;
        set_per(0, 0); cont[0] = 1'b1; en[0] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 2) begin
                chk("p0_status", 64'(o_irq_status[0]), 64'd1);
                chk("p0_ovr_clear", 64'(o_overrun[0]), 64'd0);
            end
            if (k == 3) chk("p0_ovr_next", 64'(o_overrun[0]), 64'd1);
        end
        en[0] = 1'b0; clr = 4'b0001; step(); clr = '0;

        // Lowering the period below the current count expires on the next tick.
        set_per(0, 10); cont[0] = 1'b0; en[0] = 1'b1;
        for (int k = 1; k <= 7; k++) step();
        chk("rp_count6", 64'(o_count[0 +: CW]), 64'd6);
        chk("rp_status_pre", 64'(o_irq_status[0]), 64'd0);
        set_per(0, 3);
        step();
        chk("rp_expired", 64'(o_irq_status[0]), 64'd1);
        chk("rp_count_hold", 64'(o_count[0 +: CW]), 64'd6);
        chk("rp_active", 64'(o_active[0]), 64'd0);

        // Random phase against the model.
        for (int c = 0; c < 2000; c++) begin
            for (int n = 0; n < NCH; n++) begin
                if ($urandom_range(0, 39) == 0) en[n] = ~en[n];
                if ($urandom_range(0, 49) == 0) cont[n] = ~cont[n];
                if ($urandom_range(0, 29) == 0) set_per(n, int'($urandom_range(0, 6)));
                clr[n]  = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) mask[n] = ~mask[n];
            end
            if ($urandom_range(0, 199) == 0) presc = PW'($urandom_range(0, 2));
            step();
        end
        clr = '0;
        step();
        mon_en = 1'b0;
        if (sb_q.size() != 0) chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
